// File: rtl/logic_fu_pkg.sv
// Opcode encoding shared by the logic functional unit and its evaluator.
// Width-independent; carries no state.
package logic_fu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'b000;
    localparam op_t OP_XOR  = 3'b001;
    localparam op_t OP_NAND = 3'b010;
    localparam op_t OP_OR   = 3'b011;
    localparam op_t OP_NOT  = 3'b100;
    localparam op_t OP_NOR  = 3'b101;
    localparam op_t OP_NEG  = 3'b110;
    localparam op_t OP_XNOR = 3'b111;

endpackage

// File: rtl/logic_fu_eval.sv
// Combinational opcode -> result for the eight bitwise functions.
// Zero latency, no state; never stalls.
module logic_fu_eval
    import logic_fu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        case (op)
            OP_AND:  res = a & b;
            OP_XOR:  res = a ^ b;
            OP_NAND: res = ~(a & b);
            OP_OR:   res = a | b;
            OP_NOT:  res = ~a;
            OP_NOR:  res = ~(a | b);
            // Carry out of the increment is dropped: result is modulo 2^WIDTH.
            OP_NEG:  res = ~a + WIDTH'(1);
            OP_XNOR: res = ~(a ^ b);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/logic_fu_pipe.sv
// Pipelined logic FU: result reaches the CDB STAGES-1 edges after the accept edge.
// Stages compact toward the CDB port; issue stalls only when every stage is full and ungranted.
module logic_fu_pipe
    import logic_fu_pkg::*;
#(
    parameter int  WIDTH  = 32,
    parameter int  TAG_W  = 4,
    parameter int  STAGES = 2,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  op_t              issue_op,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [WIDTH-1:0] issue_a,
    input  logic [WIDTH-1:0] issue_b,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [WIDTH-1:0] cdb_value,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy
);

    localparam int LAST = STAGES - 1;

    logic [WIDTH-1:0]  eval_res;
    logic [STAGES-1:0] v_cur;
    logic [STAGES-1:0] v_nxt;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [TAG_W-1:0]  tag_cur [STAGES];
    logic [WIDTH-1:0]  res_cur [STAGES];
    logic [OCC_W-1:0]  occupancy_q;
    logic [OCC_W-1:0]  occupancy_d;

    logic_fu_eval #(.WIDTH(WIDTH)) u_eval (
        .op  (issue_op),
        .a   (issue_a),
        .b   (issue_b),
        .res (eval_res)
    );

    // A stage empties when its content moves on; the last stage moves only on a grant.
    always_comb begin
        adv       = '0;
        adv[LAST] = v_cur[LAST] & cdb_grant;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = v_cur[k] & (~v_cur[k+1] | adv[k+1]);
        end
        issue_ready = ~flush & (~v_cur[0] | adv[0]);
        load        = '0;
        load[0]     = issue_valid & issue_ready;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_q, v_d;
        logic [TAG_W-1:0] tag_q, tag_d;
        logic [WIDTH-1:0] res_q, res_d;
        logic [TAG_W-1:0] src_tag;
        logic [WIDTH-1:0] src_res;

        if (k == 0) begin : g_src
            assign src_tag = issue_tag;
            assign src_res = eval_res;
        end else begin : g_src
            assign src_tag = tag_cur[k-1];
            assign src_res = res_cur[k-1];
        end

        // Payload only changes on a load, so a stalled head stays stable on the CDB.
        always_comb begin
            v_d   = v_q;
            tag_d = tag_q;
            res_d = res_q;
            if (load[k]) begin
                v_d   = 1'b1;
                tag_d = src_tag;
                res_d = src_res;
            end else if (adv[k]) begin
                v_d = 1'b0;
            end
            if (flush) begin
                v_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                tag_q <= '0;
                res_q <= '0;
            end else begin
                v_q   <= v_d;
                tag_q <= tag_d;
                res_q <= res_d;
            end
        end

        assign v_cur[k]   = v_q;
        assign v_nxt[k]   = v_d;
        assign tag_cur[k] = tag_q;
        assign res_cur[k] = res_q;
    end

    always_comb begin
        occupancy_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy_d = occupancy_d + OCC_W'(v_nxt[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign cdb_req   = v_cur[LAST];
    assign cdb_tag   = tag_cur[LAST];
    assign cdb_value = res_cur[LAST];
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_logic_fu_pipe.sv
// Bench for logic_fu_pipe at four width/depth points, scoreboard-checked.
module tb_logic_fu_pipe;
    import logic_fu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    // Group A: 32-bit inputs shared by the STAGES=2 and STAGES=3 instances
    logic        a_valid, a_grant, a_flush;
    logic [2:0]  a_op;
    logic [3:0]  a_tag;
    logic [31:0] a_a, a_b;
    logic        s2_ready, s2_req, s3_ready, s3_req;
    logic [3:0]  s2_tag, s3_tag;
    logic [31:0] s2_value, s3_value;
    logic [1:0]  s2_occ, s3_occ;

    // Group B: 8-bit inputs shared by the STAGES=1 and STAGES=4 instances
    logic        b_valid, b_grant, b_flush;
    logic [2:0]  b_op;
    logic [3:0]  b_tag;
    logic [7:0]  b_a, b_b;
    logic        s1_ready, s1_req, s4_ready, s4_req;
    logic [3:0]  s1_tag, s4_tag;
    logic [7:0]  s1_value, s4_value;
    logic [0:0]  s1_occ;
    logic [2:0]  s4_occ;

    logic_fu_pipe #(.WIDTH(32), .TAG_W(4), .STAGES(2)) dut_s2 (
        .clk(clk), .rst(rst), .issue_valid(a_valid), .issue_ready(s2_ready), .issue_op(a_op),
        .issue_tag(a_tag), .issue_a(a_a), .issue_b(a_b), .cdb_req(s2_req), .cdb_grant(a_grant),
        .cdb_tag(s2_tag), .cdb_value(s2_value), .flush(a_flush), .occupancy(s2_occ));

    logic_fu_pipe #(.WIDTH(32), .TAG_W(4), .STAGES(3)) dut_s3 (
        .clk(clk), .rst(rst), .issue_valid(a_valid), .issue_ready(s3_ready), .issue_op(a_op),
        .issue_tag(a_tag), .issue_a(a_a), .issue_b(a_b), .cdb_req(s3_req), .cdb_grant(a_grant),
        .cdb_tag(s3_tag), .cdb_value(s3_value), .flush(a_flush), .occupancy(s3_occ));

    logic_fu_pipe #(.WIDTH(8), .TAG_W(4), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .issue_valid(b_valid), .issue_ready(s1_ready), .issue_op(b_op),
        .issue_tag(b_tag), .issue_a(b_a), .issue_b(b_b), .cdb_req(s1_req), .cdb_grant(b_grant),
        .cdb_tag(s1_tag), .cdb_value(s1_value), .flush(b_flush), .occupancy(s1_occ));

    logic_fu_pipe #(.WIDTH(8), .TAG_W(4), .STAGES(4)) dut_s4 (
        .clk(clk), .rst(rst), .issue_valid(b_valid), .issue_ready(s4_ready), .issue_op(b_op),
        .issue_tag(b_tag), .issue_a(b_a), .issue_b(b_b), .cdb_req(s4_req), .cdb_grant(b_grant),
        .cdb_tag(s4_tag), .cdb_value(s4_value), .flush(b_flush), .occupancy(s4_occ));

    // Reference: the opcode table evaluated on 32-bit values, then cut to w bits.
    function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
        logic [31:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a ^ b;
            3'd2:    r = ~(a & b);
            3'd3:    r = a | b;
            3'd4:    r = ~a;
            3'd5:    r = ~(a | b);
            3'd6:    r = 32'd0 - a;
            default: r = ~(a ^ b);
        endcase
        if (w < 32) r = r & ((32'd1 << w) - 32'd1);
        return r;
    endfunction

    task automatic clr_inputs;
        a_valid = 0; a_grant = 0; a_flush = 0; a_op = 0; a_tag = 0; a_a = 0; a_b = 0;
        b_valid = 0; b_grant = 0; b_flush = 0; b_op = 0; b_tag = 0; b_a = 0; b_b = 0;
    endtask

    task automatic do_reset;
        clr_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        clr_inputs();
        rst = 1'b1;
        @(negedge clk);
        n_total++; if ({s2_req, s2_occ, s2_tag, s2_value} !== '0) $display("FAIL reset_s2 got %h want 0", {s2_req, s2_occ, s2_tag, s2_value}); else n_pass++;
        n_total++; if ({s3_req, s3_occ, s3_tag, s3_value} !== '0) $display("FAIL reset_s3 got %h want 0", {s3_req, s3_occ, s3_tag, s3_value}); else n_pass++;
        n_total++; if ({s1_req, s1_occ, s1_tag, s1_value} !== '0) $display("FAIL reset_s1 got %h want 0", {s1_req, s1_occ, s1_tag, s1_value}); else n_pass++;
        n_total++; if ({s4_req, s4_occ, s4_tag, s4_value} !== '0) $display("FAIL reset_s4 got %h want 0", {s4_req, s4_occ, s4_tag, s4_value}); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_total++; if ({s1_ready, s2_ready, s3_ready, s4_ready} !== 4'hF) $display("FAIL reset_ready got %b want 1111", {s1_ready, s2_ready, s3_ready, s4_ready}); else n_pass++;
    endtask

    task automatic test_func_sweep;
        logic [31:0] exp_v [8];
        int got = 0;
        exp_v = '{32'h00000007, 32'h619CD360, 32'hFFFFFFF8, 32'h619CD367,
                  32'hFFFFFFF8, 32'h9E632C98, 32'hFFFFFFF9, 32'h9E632C9F};
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            a_grant = 1'b1; a_valid = (c < 8); a_op = 3'(c); a_tag = 4'(c);
            a_a = 32'h00000007; a_b = 32'h619CD367;
            @(negedge clk);
            if (c < 8) begin
                n_total++; if (s2_ready !== 1'b1) $display("FAIL sweep_ready c=%0d got %b want 1", c, s2_ready); else n_pass++;
            end
            if (s2_req === 1'b1) begin
                n_total++;
                if (got >= 8) $display("FAIL sweep_extra c=%0d got tag %h want no result", c, s2_tag);
                else if (c != got + 2 || s2_tag !== 4'(got) || s2_value !== exp_v[got])
                    $display("FAIL sweep_result c=%0d got tag %h val %h want c=%0d tag %h val %h", c, s2_tag, s2_value, got + 2, got, exp_v[got]);
                else n_pass++;
                got++;
            end
        end
        n_total++; if (got != 8) $display("FAIL sweep_count got %0d want 8", got); else n_pass++;
        clr_inputs();
    endtask

    task automatic test_backpressure;
        exp_t q[$];
        int drained = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            a_valid = 1'b1; a_op = 3'($urandom_range(7)); a_tag = 4'(c + 1);
            a_a = $urandom; a_b = $urandom;
            @(negedge clk);
            n_total++; if (s3_ready !== (c < 3)) $display("FAIL bp_ready c=%0d got %b want %b", c, s3_ready, c < 3); else n_pass++;
            if (c < 3) q.push_back('{tag: a_tag, val: ref_fn(a_op, a_a, a_b, 32), cyc: c});
        end
        @(posedge clk); #1 a_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_total++;
            if ({s3_req, s3_ready, s3_occ, s3_tag, s3_value} !== {1'b1, 1'b0, 2'd3, q[0].tag, q[0].val})
                $display("FAIL bp_hold c=%0d got req %b rdy %b occ %0d tag %h val %h want 1 0 3 %h %h", c, s3_req, s3_ready, s3_occ, s3_tag, s3_value, q[0].tag, q[0].val);
            else n_pass++;
            @(posedge clk); #1;
        end
        a_grant = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (s3_req === 1'b1) begin
                n_total++;
                if (q.size() == 0) $display("FAIL bp_drain_extra got tag %h want none", s3_tag);
                else if (s3_tag !== q[0].tag || s3_value !== q[0].val)
                    $display("FAIL bp_drain got tag %h val %h want %h %h", s3_tag, s3_value, q[0].tag, q[0].val);
                else n_pass++;
                if (q.size() != 0) void'(q.pop_front());
                drained++;
            end
            @(posedge clk); #1;
        end
        n_total++; if (drained != 3 || s3_occ !== 2'd0) $display("FAIL bp_drain_count got %0d occ %0d want 3 occ 0", drained, s3_occ); else n_pass++;
        clr_inputs();
    endtask

    task automatic test_flush;
        logic [31:0] exp_v;
        int seen = 0;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            a_valid = 1'b1; a_op = 3'($urandom_range(7)); a_tag = 4'(4'hA + c); a_a = $urandom; a_b = $urandom;
        end
        @(posedge clk); #1;
        a_valid = 1'b1; a_tag = 4'hC; a_flush = 1'b1; a_grant = 1'b1;
        @(negedge clk);
        n_total++; if ({s2_ready, s2_occ} !== {1'b0, 2'd2}) $display("FAIL flush_ready got rdy %b occ %0d want 0 2", s2_ready, s2_occ); else n_pass++;
        @(posedge clk); #1;
        a_flush = 1'b0; a_valid = 1'b0;
        @(negedge clk);
        n_total++; if ({s2_req, s2_occ} !== 3'd0) $display("FAIL flush_clear got req %b occ %0d want 0 0", s2_req, s2_occ); else n_pass++;
        @(posedge clk); #1;
        a_valid = 1'b1; a_op = 3'($urandom_range(7)); a_tag = 4'hD; a_a = $urandom; a_b = $urandom;
        exp_v = ref_fn(a_op, a_a, a_b, 32);
        @(posedge clk); #1 a_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (s2_req === 1'b1) begin
                seen++;
                n_total++; if (s2_tag !== 4'hD || s2_value !== exp_v) $display("FAIL flush_next got tag %h val %h want D %h", s2_tag, s2_value, exp_v); else n_pass++;
            end
            @(posedge clk); #1;
        end
        n_total++; if (seen != 1) $display("FAIL flush_count got %0d want 1", seen); else n_pass++;
        clr_inputs();
    endtask

    task automatic test_async_reset;
        int seen = 0;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            a_valid = 1'b1; a_op = 3'($urandom_range(7)); a_tag = 4'(c + 1); a_a = $urandom; a_b = $urandom;
        end
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk);
        n_total++; if ({s2_req, s2_occ} !== {1'b1, 2'd2}) $display("FAIL areset_pre got req %b occ %0d want 1 2", s2_req, s2_occ); else n_pass++;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        n_total++; if ({s2_req, s2_occ, s3_req, s3_occ} !== 6'd0) $display("FAIL areset_now got %b want 000000", {s2_req, s2_occ, s3_req, s3_occ}); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        a_valid = 1'b1; a_op = 3'b110; a_a = 32'd0; a_b = $urandom; a_tag = 4'd5; a_grant = 1'b1;
        @(posedge clk); #1 a_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (s2_req === 1'b1) begin
                seen++;
                n_total++; if (s2_tag !== 4'd5 || s2_value !== 32'd0) $display("FAIL areset_first got tag %h val %h want 5 0", s2_tag, s2_value); else n_pass++;
            end
            @(posedge clk); #1;
        end
        n_total++; if (seen != 1) $display("FAIL areset_count got %0d want 1", seen); else n_pass++;
        clr_inputs();
    endtask

    task automatic test_corners;
        int lat1 = -1, lat4 = -1, n1 = 0, n4 = 0;
        do_reset();
        b_grant = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if ({s1_req, s1_occ, s4_req, s4_occ} !== 5'd0) $display("FAIL corner_spurious got %b want 00000", {s1_req, s1_occ, s4_req, s4_occ}); else n_pass++;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            b_valid = (c == 0); b_op = 3'b110; b_a = 8'h80; b_b = 8'($urandom); b_tag = 4'd3;
            @(negedge clk);
            if (c == 2) begin
                n_total++; if (s4_occ !== 3'd1) $display("FAIL corner_inflight got occ %0d want 1", s4_occ); else n_pass++;
            end
            if (s1_req === 1'b1) begin
                n1++; if (lat1 < 0) lat1 = c;
                n_total++; if (s1_tag !== 4'd3 || s1_value !== 8'h80) $display("FAIL corner_s1 got tag %h val %h want 3 80", s1_tag, s1_value); else n_pass++;
            end
            if (s4_req === 1'b1) begin
                n4++; if (lat4 < 0) lat4 = c;
                n_total++; if (s4_tag !== 4'd3 || s4_value !== 8'h80) $display("FAIL corner_s4 got tag %h val %h want 3 80", s4_tag, s4_value); else n_pass++;
            end
        end
        n_total++; if (lat1 != 1 || n1 != 1) $display("FAIL corner_lat1 got lat %0d n %0d want 1 1", lat1, n1); else n_pass++;
        n_total++; if (lat4 != 4 || n4 != 1) $display("FAIL corner_lat4 got lat %0d n %0d want 4 1", lat4, n4); else n_pass++;
        clr_inputs();
    endtask

    // Scoreboard: every in-flight op holds one stage, so the queue length is the occupancy.
    task automatic test_random;
        exp_t q[$];
        logic exp_rdy;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            a_valid = ($urandom_range(3) != 0); a_op = 3'($urandom_range(7)); a_tag = 4'($urandom);
            a_a = $urandom; a_b = $urandom; a_grant = ($urandom_range(1) != 0);
            a_flush = ($urandom_range(19) == 0);
            @(negedge clk);
            exp_rdy = !a_flush && (q.size() < 3 || a_grant);
            n_total++; if (s3_ready !== exp_rdy) $display("FAIL rand_ready c=%0d got %b want %b", c, s3_ready, exp_rdy); else n_pass++;
            n_total++; if (s3_occ !== 2'(q.size())) $display("FAIL rand_occ c=%0d got %0d want %0d", c, s3_occ, q.size()); else n_pass++;
            if (s3_req === 1'b1) begin
                n_total++;
                if (q.size() == 0) $display("FAIL rand_spurious c=%0d got tag %h want no request", c, s3_tag);
                else if (s3_tag !== q[0].tag || s3_value !== q[0].val || c - q[0].cyc < 3)
                    $display("FAIL rand_result c=%0d got tag %h val %h want %h %h issued c=%0d", c, s3_tag, s3_value, q[0].tag, q[0].val, q[0].cyc);
                else n_pass++;
            end
            if (a_flush) q.delete();
            else begin
                if (s3_req === 1'b1 && a_grant && q.size() != 0) void'(q.pop_front());
                if (a_valid && exp_rdy) q.push_back('{tag: a_tag, val: ref_fn(a_op, a_a, a_b, 32), cyc: c});
            end
        end
        clr_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        test_reset();
        test_func_sweep();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_corners();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
